// File: rtl/uart_tx_arb_if.sv
// Requester byte streams plus the uart_tx byte/send/busy link, grouped for the arbiter.
interface uart_tx_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_send;
  logic                    tx_busy;

  // master: requesters and the transmitter; slave: the arbiter itself
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_send
  );
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_send
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Frame-locked round-robin arbiter feeding one uart_tx; accept at T gives tx_send at T+1.
// Define UART_ARB_PRIO_EN to make requester 0 win every unlocked arbitration.
module uart_tx_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_FRAME = 16,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic            clock,
  input  logic            rst,
  uart_tx_arb_if.slave    bus,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            frame_cut
);

  localparam int               CNT_W     = (MAX_FRAME > 0) ? $clog2(MAX_FRAME + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_FRAME);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, HOLD, KICK, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_send_q, tx_send_d;
  logic              grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_cut_q, frame_cut_d;

  logic              accept;
  logic [ID_W-1:0]   win;
  logic [ID_W:0]     pick;

  // Scan from last_grant+N_REQ down to last_grant+1 so the nearest valid requester wins.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                            input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] cand;
    logic [ID_W:0]   res;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last) + k) % N_REQ);
      if (vld[cand]) res = {1'b1, cand};
    end
`ifdef UART_ARB_PRIO_EN
    if (vld[0]) res = {1'b1, {ID_W{1'b0}}};
`endif
    return res;
  endfunction

  assign pick = rr_pick(bus.req_valid, last_grant_q);

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    tx_send_d     = 1'b0;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    frame_cut_d   = 1'b0;
    accept        = 1'b0;
    win           = grant_id_q;

    case (state_q)
      IDLE: begin
        if (!bus.tx_busy && pick[ID_W]) begin
          accept = 1'b1;
          win    = pick[ID_W-1:0];
          cnt_d  = CNT_W'(1);
        end
      end
      HOLD: begin
        if (!bus.tx_busy && bus.req_valid[grant_id_q]) begin
          accept = 1'b1;
          win    = grant_id_q;
          if (MAX_FRAME != 0 && cnt_q != MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KICK:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q || (MAX_FRAME != 0 && cnt_q == MAX_CNT)) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            cnt_d         = '0;
            frame_cut_d   = !last_q;
`ifdef UART_ARB_PRIO_EN
            // requester 0 sits outside the rotation among the others
            if (grant_id_q != '0) last_grant_d = grant_id_q;
`else
            last_grant_d  = grant_id_q;
`endif
          end else begin
            state_d = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Never accept in the reset cycle: the byte would be lost.
    if (rst) accept = 1'b0;

    if (accept) begin
      tx_data_d     = bus.req_data[int'(win)*DATA_W +: DATA_W];
      last_d        = bus.req_last[win];
      grant_id_d    = win;
      grant_valid_d = 1'b1;
      tx_send_d     = 1'b1;
      state_d       = KICK;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_data_q     <= '0;
      tx_send_q     <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant_q  <= LAST_INIT;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      frame_cut_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_send_q     <= tx_send_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      frame_cut_q   <= frame_cut_d;
    end
  end

  assign bus.req_ready = accept ? (N_REQ'(1) << win) : '0;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_send   = tx_send_q;
  assign grant_valid   = grant_valid_q;
  assign grant_id      = grant_id_q;
  assign frame_cut     = frame_cut_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb with MAX_FRAME=4 and a behavioural uart_tx busy model.
module tb_uart_tx_arb;
  localparam int N_REQ    = 4;
  localparam int DATA_W   = 8;
  localparam int BUSY_LEN = 4;

  typedef struct { logic [1:0] id; logic [7:0] data; logic last; } stim_t;
  typedef struct { logic [1:0] id; logic [7:0] data; logic cut;  } exp_t;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       frame_cut;
  logic       busy;
  int         bcnt;
  int         cyc = 0;
  int         checks = 0;
  int         fails  = 0;
  logic       cut_seen = 1'b0;

  stim_t sq[$];
  exp_t  exp_q[$];
  int    acc_q[$];

  uart_tx_arb_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_FRAME(4)) dut (
    .clock       (clock),
    .rst         (rst),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .frame_cut   (frame_cut)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // uart_tx stand-in: busy for BUSY_LEN cycles after each send pulse
  assign bus.tx_busy = busy;
  always @(posedge clock) begin
    if (rst) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (bus.tx_send) begin
      busy <= 1'b1;
      bcnt <= BUSY_LEN - 1;
    end else if (busy) begin
      if (bcnt == 0) busy <= 1'b0;
      else           bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [1:0] id, input logic [7:0] d, input logic last);
    stim_t s;
    s.id = id; s.data = d; s.last = last;
    sq.push_back(s);
  endtask

  task automatic expect_tx(input logic [1:0] id, input logic [7:0] d, input logic cut);
    exp_t e;
    e.id = id; e.data = d; e.cut = cut;
    exp_q.push_back(e);
  endtask

  function automatic int head_of(input int id);
    for (int j = 0; j < sq.size(); j++)
      if (int'(sq[j].id) == id) return j;
    return -1;
  endfunction

  // Requester driver: present each requester's oldest byte, retire it on req_ready.
  initial begin
    int          h;
    int          acc_cycle;
    logic [3:0]  rdy;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < N_REQ; i++) begin
        h = head_of(i);
        if (h >= 0) begin
          bus.req_valid[i]           = 1'b1;
          bus.req_data[i*DATA_W +: DATA_W] = sq[h].data;
          bus.req_last[i]            = sq[h].last;
        end else begin
          bus.req_valid[i]           = 1'b0;
          bus.req_data[i*DATA_W +: DATA_W] = '0;
          bus.req_last[i]            = 1'b0;
        end
      end
      #4;
      rdy       = bus.req_ready;
      acc_cycle = cyc;
      @(posedge clock);
      if (rdy != '0) begin
        chk("ready_onehot", $countones(rdy), 1);
        for (int i = 0; i < N_REQ; i++) begin
          if (rdy[i]) begin
            h = head_of(i);
            if (h >= 0) sq.delete(h);
            acc_q.push_back(acc_cycle);
          end
        end
      end
    end
  end

  // Monitor: every send pulse is checked against the next expected byte.
  always @(negedge clock) begin
    exp_t e;
    int   a;
    if (!rst) begin
      if (frame_cut) cut_seen = 1'b1;
      if (bus.tx_send) begin
        chk("send_while_busy", {31'd0, bus.tx_busy}, 0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_send: got data %0h id %0d expected no send", bus.tx_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {24'd0, bus.tx_data}, {24'd0, e.data});
          chk("grant_id", {30'd0, grant_id}, {30'd0, e.id});
          chk("grant_valid_on_send", {31'd0, grant_valid}, 1);
          chk("frame_cut_before", {31'd0, cut_seen}, {31'd0, e.cut});
          cut_seen = 1'b0;
          if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            chk("accept_to_send", cyc - a, 1);
          end else begin
            checks++;
            fails++;
            $display("FAIL accept_to_send: got send with no accept expected an accept first");
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clock);
      n++;
      if (sq.size() == 0 && exp_q.size() == 0 && !bus.tx_busy && !bus.tx_send) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      fails++;
      $display("FAIL %s_drain: got pending stim %0d exp %0d expected 0 0", name, sq.size(), exp_q.size());
      sq.delete(); exp_q.delete(); acc_q.delete();
    end
  endtask

  task automatic wait_exp_le(input string name, input int lim);
    int n = 0;
    while (exp_q.size() > lim && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_progress"}, (exp_q.size() <= lim) ? 32'd1 : 32'd0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready",   {28'd0, bus.req_ready}, 0);
    chk("rst_tx_send",     {31'd0, bus.tx_send}, 0);
    chk("rst_tx_data",     {24'd0, bus.tx_data}, 0);
    chk("rst_grant_valid", {31'd0, grant_valid}, 0);
    chk("rst_grant_id",    {30'd0, grant_id}, 0);
    chk("rst_frame_cut",   {31'd0, frame_cut}, 0);
    rst = 1'b0;

    // contention: two rounds, each starting at requester 0
    for (int r = 0; r < 2; r++) begin
      send(0, 8'h11, 1); send(1, 8'h22, 1); send(3, 8'h33, 1);
      expect_tx(0, 8'h11, 0); expect_tx(1, 8'h22, 0); expect_tx(3, 8'h33, 0);
      wait_drain("contention");
    end

    // single byte
    send(2, 8'hA5, 1);
    expect_tx(2, 8'hA5, 0);
    wait_drain("single");
    chk("single_grant_released", {31'd0, grant_valid}, 0);

    // frame lock: requester 0 shows up mid-frame and must wait
    send(1, 8'h3C, 0); send(1, 8'h3D, 0); send(1, 8'h3E, 1);
    expect_tx(1, 8'h3C, 0); expect_tx(1, 8'h3D, 0); expect_tx(1, 8'h3E, 0); expect_tx(0, 8'h0B, 0);
    wait_exp_le("lock", 3);
    send(0, 8'h0B, 1);
    wait_drain("lock");
    chk("lock_grant_released", {31'd0, grant_valid}, 0);

    // last_grant is 0 here: plain rotation picks 1, priority mode picks 0
    send(0, 8'h02, 1); send(1, 8'h12, 1);
`ifdef UART_ARB_PRIO_EN
    expect_tx(0, 8'h02, 0); expect_tx(1, 8'h12, 0);
`else
    expect_tx(1, 8'h12, 0); expect_tx(0, 8'h02, 0);
`endif
    wait_drain("prio");

    // MAX_FRAME=4 cut with requester 3 waiting
    for (int b = 0; b < 6; b++) send(2, 8'h40 + 8'(b), 0);
    send(3, 8'h90, 1);
    for (int b = 0; b < 4; b++) expect_tx(2, 8'h40 + 8'(b), 0);
    expect_tx(3, 8'h90, 1);
    expect_tx(2, 8'h44, 0); expect_tx(2, 8'h45, 0);
    wait_drain("maxframe");
    chk("maxframe_still_locked", {31'd0, grant_valid}, 1);
    chk("maxframe_lock_id", {30'd0, grant_id}, 2);

    // reset while in WAIT_DONE of a locked frame
    send(2, 8'h77, 0);
    expect_tx(2, 8'h77, 0);
    wait_exp_le("pre_reset", 0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    send(0, 8'h0A, 1); send(2, 8'h78, 1);
    expect_tx(0, 8'h0A, 0); expect_tx(2, 8'h78, 0);
    @(negedge clock);
    chk("midrst_tx_send",     {31'd0, bus.tx_send}, 0);
    chk("midrst_grant_valid", {31'd0, grant_valid}, 0);
    chk("midrst_req_ready",   {28'd0, bus.req_ready}, 0);
    chk("midrst_frame_cut",   {31'd0, frame_cut}, 0);
    rst = 1'b0;
    wait_drain("post_reset");
    chk("final_grant_released", {31'd0, grant_valid}, 0);
    chk("final_no_stray_cut", {31'd0, cut_seen}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one uart_tx transmitter (tx_data / tx_send / tx_busy interface) between N_REQ byte-stream requesters.
- Sequences the transmitter one byte at a time.
- Holds the grant for a whole frame, delimited by req_last, so multi-byte messages are not interleaved.
- Sits between on-chip message sources (status reporter, debug console, loopback of uart_rx data) and the single uart_tx instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, byte width; matches uart_tx.
- MAX_FRAME, 16, max bytes per locked frame before the grant is forcibly released; 0 = unlimited.

Ports:
- clock  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  requester i has a byte ready.
- req_data  in  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  byte from requester i is the last of its frame.
- req_ready  out  N_REQ  one-cycle accept strobe; at most one bit high.
- tx_data  out  DATA_W  byte to uart_tx; registered.
- tx_send  out  1  one-cycle start pulse to uart_tx.
- tx_busy  in  1  uart_tx transmitting.
- grant_valid  out  1  a requester currently owns the transmitter.
- grant_id  out  max(1,$clog2(N_REQ))  owning requester index.
- frame_cut  out  1  one-cycle pulse when MAX_FRAME forced a release.

Behaviour:
- Single clock; rst is synchronous, active-high.
- Reset values:
  - req_ready, tx_data, tx_send, grant_valid, grant_id, frame_cut = 0.
  - Internal last_grant = N_REQ-1, so the first search starts at requester 0.
  - Byte counter = 0; state = IDLE.
- Reset mid-operation: everything returns to reset values next cycle and any accepted byte is dropped here; uart_tx is reset by the same rst.
- States: IDLE, HOLD, KICK, WAIT_BUSY, WAIT_DONE.
- IDLE (unlocked):
  - When tx_busy==0 and any req_valid, pick winner w = first i with req_valid[i], searching last_grant+1 .. last_grant+N_REQ mod N_REQ.
  - Same cycle: req_ready[w]=1; register tx_data<=req_data[w], last_q<=req_last[w], grant_id<=w, grant_valid<=1; counter<=1; go to KICK.
  - If tx_busy==1 in IDLE, accept nothing.
- HOLD (locked to grant_id):
  - Only req_valid[grant_id] is considered; other requesters wait indefinitely.
  - When req_valid[grant_id] and tx_busy==0: accept as in IDLE, counter++, go to KICK.
- KICK: tx_send=1 for exactly this cycle, then WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy==1, then WAIT_DONE.
- WAIT_DONE: stay until tx_busy==0, then:
  - If last_q==1: release, i.e. grant_valid<=0, last_grant<=grant_id, counter<=0, go to IDLE.
  - Else if MAX_FRAME!=0 and counter==MAX_FRAME: release as above and pulse frame_cut=1 for one cycle.
  - Else go to HOLD.
- Latency and timing:
  - Accept at cycle T gives tx_send at T+1.
  - tx_data stable from T+1 until the next accept.
  - Next accept no earlier than the cycle after tx_busy falls.
- req_ready is combinational from state and req_valid; requesters must hold data/last stable while req_valid=1 and not yet accepted.
- Simultaneous requests in IDLE: the round-robin order decides; exactly one req_ready bit high.
- Counter wraps never: it saturates at MAX_FRAME, which triggers the release; width is $clog2(MAX_FRAME+1) (min 1).

Optional Feature:
- Macro: UART_ARB_PRIO_EN.
- Defined:
  - Requester 0 is high priority: in IDLE, if req_valid[0]==1 it wins regardless of last_grant.
  - It cannot pre-empt a locked frame, but MAX_FRAME still bounds its wait.
  - last_grant is not updated when requester 0 releases, so the rotation among 1..N_REQ-1 is preserved.
- Undefined: pure round-robin as above.

Test Plan:
- Single byte: req_valid[2]=1, data 8'hA5, last=1 → req_ready[2] one cycle, tx_send next cycle with tx_data=8'hA5, grant_id=2; grant_valid drops after tx_busy falls.
- Contention: req 0,1,3 valid simultaneously, each 1-byte frame (8'h11,8'h22,8'h33) → serial output 11, 22, 33; a repeat round starts at 0 again.
- Frame lock: req1 sends 3-byte frame 8'h3C,8'h3D,8'h3E (last on third) while req0 is valid → all three bytes go out before any req0 byte; tx_send never overlaps tx_busy.
- MAX_FRAME=4, req2 streams 6 bytes with last never set, req3 waiting → 4 bytes from req2, then frame_cut pulse, then req3 byte, then the remaining req2 bytes.
- rst asserted during WAIT_DONE → next cycle tx_send=0, grant_valid=0, req_ready=0; post-reset first grant goes to requester 0.
- With UART_ARB_PRIO_EN: last_grant=0, req0 and req1 valid in IDLE → req0 wins; without the macro → req1 wins.
